// File: rtl/byte_striping_pkg.sv
// Shared lane/byte geometry for the 4-lane byte striper and unstriper.
package byte_striping_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_SEL_W = $clog2(LANES);
    localparam int unsigned WORD_W     = LANES * DATA_WIDTH;

    // One striped word: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
    typedef logic [LANES-1:0][DATA_WIDTH-1:0] word_t;

endpackage : byte_striping_pkg

// File: rtl/unstriping_word_fifo.sv
// Two-entry word buffer feeding the unstriper output mux.
module unstriping_word_fifo
    import byte_striping_pkg::*;
#(
    parameter int unsigned WORD_BITS = WORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [WORD_BITS-1:0] i_wdata,
    input  logic                 i_pop,
    output logic [WORD_BITS-1:0] o_head,
    output logic                 o_ready,
    output logic                 o_valid
);

    logic [WORD_BITS-1:0] r_buf [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    // Storage, pointers and occupancy; push and pop in the same cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_buf[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Status flags come from registered occupancy only.
    always_comb begin
        o_head  = r_buf[r_rd_ptr];
        o_ready = (r_count != 2'd2);
        o_valid = (r_count != 2'd0);
    end

endmodule : unstriping_word_fifo

// File: rtl/byte_unstriping.sv
// Re-serialises one multi-lane word per handshake into a byte stream, lane0 first.
module byte_unstriping
    import byte_striping_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = byte_striping_pkg::DATA_WIDTH,
    parameter int unsigned LANES      = byte_striping_pkg::LANES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LANES*DATA_WIDTH-1:0] lanes_data,
    input  logic                        lanes_valid,
    output logic                        lanes_ready,
    output logic [DATA_WIDTH-1:0]       rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        overflow
);

    localparam int unsigned SEL_W  = $clog2(LANES);
    localparam int unsigned WORD_B = LANES * DATA_WIDTH;

    logic [SEL_W-1:0]                  r_byte_sel;
    logic                              r_overflow;
    logic                              w_push;
    logic                              w_pop_byte;
    logic                              w_pop_word;
    logic                              w_ready;
    logic                              w_valid;
    logic [WORD_B-1:0]                 w_head_flat;
    logic [LANES-1:0][DATA_WIDTH-1:0]  w_head;

    unstriping_word_fifo #(
        .WORD_BITS (WORD_B)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (lanes_data),
        .i_pop   (w_pop_word),
        .o_head  (w_head_flat),
        .o_ready (w_ready),
        .o_valid (w_valid)
    );

    // Handshake decode and byte mux over the head word.
    always_comb begin
        w_push      = lanes_valid && w_ready;
        w_pop_byte  = w_valid && rx_ready;
        w_pop_word  = w_pop_byte && (r_byte_sel == SEL_W'(LANES - 1));
        w_head      = w_head_flat;
        lanes_ready = w_ready;
        rx_valid    = w_valid;
        rx_data     = w_head[r_byte_sel];
        overflow    = r_overflow;
    end

    // Lane selector advances per accepted byte; overflow flags a refused word for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_sel <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop_byte) begin
                r_byte_sel <= r_byte_sel + SEL_W'(1);
            end
            r_overflow <= lanes_valid && !w_ready;
        end
    end

endmodule : byte_unstriping
